matrix_scan_driver: RTL and testbench

Time-multiplexed row scanner for the 16x16 LED dot-matrix board. It steps a row counter at a programmable rate and looks up the column bits for the current row from an internal multi-pattern glyph ROM. It applies a per-row blanking window against ghosting and an optional per-frame horizontal rotation (scroll). Pattern changes are applied only at frame boundaries, so a frame never mixes two glyphs.

---
 rtl/matrix_pkg.sv | 9 +
 rtl/matrix_scan_if.sv | 26 ++
 rtl/matrix_glyph_rom.sv | 42 ++++
 rtl/matrix_scan_driver.sv | 84 ++++++++
 tb/tb_matrix_scan_driver.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// Shared constants for the LED dot-matrix scan driver.
package matrix_pkg;
   localparam int ROWS_DEF   = 16;
   localparam int COLS_DEF   = 16;
   localparam int PAT_BOX    = 0;
   localparam int PAT_BORDER = 1;
   localparam int PAT_CHECK  = 2;
   localparam int PAT_DIAG   = 3;
endpackage

// File: rtl/matrix_scan_if.sv
// Control inputs and scan outputs of the matrix scan driver.
interface matrix_scan_if
   import matrix_pkg::*;
#(
   parameter int ROWS = ROWS_DEF,
   parameter int COLS = COLS_DEF,
   parameter int NPAT = 4
);
   logic [$clog2(NPAT)-1:0] pat_sel;
   logic                    pat_load;
   logic                    scroll_en;
   logic                    scroll_dir;
   logic [$clog2(ROWS)-1:0] row_bin;
   logic [COLS-1:0]         col;
   logic                    frame_start;

   modport master (
      output pat_sel, pat_load, scroll_en, scroll_dir,
      input  row_bin, col, frame_start
   );

   modport slave (
      input  pat_sel, pat_load, scroll_en, scroll_dir,
      output row_bin, col, frame_start
   );
endinterface

// File: rtl/matrix_glyph_rom.sv
// Combinational glyph table: (pattern, row) -> column bits.
module matrix_glyph_rom
   import matrix_pkg::*;
#(
   parameter int ROWS = ROWS_DEF,
   parameter int COLS = COLS_DEF,
   parameter int NPAT = 4,
   localparam int RW = $clog2(ROWS),
   localparam int PW = $clog2(NPAT)
) (
   input  logic [PW-1:0]   pat,
   input  logic [RW-1:0]   row,
   output logic [COLS-1:0] bits
);
   logic [COLS-1:0] edge_bits;

   assign edge_bits = COLS'(1) | (COLS'(1) << (COLS - 1));

   always_comb begin
      bits = '0;
      unique case (1'b1)
         pat == PW'(PAT_BOX): begin
            if (row inside {RW'(0), RW'(14), RW'(15)})
               bits = '0;
            else if (row inside {RW'(1), RW'(7), RW'(13)})
               bits = COLS'(16'h0FF0);
            else
               bits = COLS'(16'h0810);
         end
         pat == PW'(PAT_BORDER):
            bits = (row == '0 || row == RW'(ROWS - 1))
                 ? '1 : edge_bits;
         pat == PW'(PAT_CHECK):
            bits = row[0] ? {(COLS/2){2'b01}}
                          : {(COLS/2){2'b10}};
         pat == PW'(PAT_DIAG):
            bits = (COLS'(1) << (COLS - 1)) >> row;
         default:
            bits = '0;
      endcase
   end
endmodule

// File: rtl/matrix_scan_driver.sv
// Row scanner: divider, row counter, frame-aligned pattern
// switch, per-frame scroll, rotate and blanking mask.
module matrix_scan_driver
   import matrix_pkg::*;
#(
   parameter int ROWS  = ROWS_DEF,
   parameter int COLS  = COLS_DEF,
   parameter int DIV   = 1000,
   parameter int BLANK = 50,
   parameter int NPAT  = 4
) (
   input logic          clk,
   input logic          rst,
   matrix_scan_if.slave bus
);
   localparam int DW = $clog2(DIV);
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam int PW = $clog2(NPAT);

   logic [DW-1:0]     div_cnt;
   logic [RW-1:0]     row;
   logic [PW-1:0]     pat;
   logic [PW-1:0]     pend_pat;
   logic              pend_vld;
   logic [CW-1:0]     offset;
   logic              frame_start;
   logic              row_tick;
   logic              frame_edge;
   logic [COLS-1:0]   rom;
   logic [2*COLS-1:0] rot;

   assign row_tick   = div_cnt == DW'(DIV - 1);
   assign frame_edge = row_tick && row == RW'(ROWS - 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt     <= '0;
         row         <= '0;
         pat         <= '0;
         pend_pat    <= '0;
         pend_vld    <= 1'b0;
         offset      <= '0;
         frame_start <= 1'b0;
      end else begin
         div_cnt     <= row_tick ? '0 : div_cnt + 1'b1;
         frame_start <= frame_edge;
         if (row_tick)
            row <= row + 1'b1;
         // A load landing on the frame edge wins over the pending one.
         if (frame_edge) begin
            if (bus.pat_load)
               pat <= bus.pat_sel;
            else if (pend_vld)
               pat <= pend_pat;
            pend_vld <= 1'b0;
            if (bus.scroll_en)
               offset <= bus.scroll_dir ? offset - 1'b1
                                        : offset + 1'b1;
         end else if (bus.pat_load) begin
            pend_pat <= bus.pat_sel;
            pend_vld <= 1'b1;
         end
      end
   end

   matrix_glyph_rom #(
      .ROWS (ROWS),
      .COLS (COLS),
      .NPAT (NPAT)
   ) u_rom (
      .pat  (pat),
      .row  (row),
      .bits (rom)
   );

   // Upper half of the doubled word is the rotate-left result.
   assign rot = {rom, rom} << offset;

   assign bus.row_bin     = row;
   assign bus.frame_start = frame_start;
   assign bus.col         = (div_cnt < DW'(BLANK))
                          ? '0 : rot[2*COLS-1:COLS];
endmodule

// File: tb/tb_matrix_scan_driver.sv
// Self-checking bench: time-indexed reference model,
// directed scenarios and randomized control traffic.
module tb_matrix_scan_driver;
   localparam int ROWS  = 16;
   localparam int COLS  = 16;
   localparam int DIV   = 4;
   localparam int BLANK = 1;
   localparam int NPAT  = 4;
   localparam int FRAME = ROWS * DIV;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   chk_en = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   int m_t = 0;
   int m_pat = 0;
   int m_off = 0;
   int m_req = -1;
   bit m_fs = 1'b0;

   always #5 clk = ~clk;

   matrix_scan_if #(
      .ROWS (ROWS), .COLS (COLS), .NPAT (NPAT)
   ) bus ();

   matrix_scan_driver #(
      .ROWS (ROWS), .COLS (COLS), .DIV (DIV),
      .BLANK (BLANK), .NPAT (NPAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [15:0] glyph(int p, int r);
      if (p == 0) begin
         if (r == 0 || r == 14 || r == 15) return 16'h0000;
         if (r == 1 || r == 7 || r == 13) return 16'h0FF0;
         return 16'h0810;
      end
      if (p == 1) return (r == 0 || r == 15) ? 16'hFFFF : 16'h8001;
      if (p == 2) return (r % 2 == 0) ? 16'hAAAA : 16'h5555;
      if (p == 3) return 16'h0001 << (15 - r);
      return 16'h0000;
   endfunction

   function automatic logic [15:0] exp_col(int t, int p, int off);
      logic [15:0] g;
      logic [15:0] c;
      if (t % DIV < BLANK) return 16'h0000;
      g = glyph(p, (t / DIV) % ROWS);
      c = '0;
      for (int i = 0; i < COLS; i++)
         c[(i + off) % COLS] = g[i];
      return c;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0d: got %0h expected %0h",
                  name, m_t, act, exp);
      end
   endtask

   // Model: time since reset, frame-aligned pattern and offset.
   always @(posedge clk) begin
      if (rst) begin
         m_t   <= 0;
         m_pat <= 0;
         m_off <= 0;
         m_req <= -1;
         m_fs  <= 1'b0;
      end else begin
         m_t  <= m_t + 1;
         m_fs <= (m_t % FRAME) == FRAME - 1;
         if ((m_t % FRAME) == FRAME - 1) begin
            if (bus.pat_load)
               m_pat <= int'(bus.pat_sel);
            else if (m_req >= 0)
               m_pat <= m_req;
            m_req <= -1;
            if (bus.scroll_en)
               m_off <= (m_off + (bus.scroll_dir ? COLS - 1 : 1)) % COLS;
         end else if (bus.pat_load) begin
            m_req <= int'(bus.pat_sel);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("row_bin", 32'(bus.row_bin), 32'((m_t / DIV) % ROWS));
         check("col", 32'(bus.col), 32'(exp_col(m_t, m_pat, m_off)));
         check("frame_start", 32'(bus.frame_start), 32'(m_fs));
      end
   end

   task automatic goto(int target);
      int guard = 0;
      while (m_t < target && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (m_t != target) begin
         n_tests++;
         n_fail++;
         $display("FAIL goto: at t=%0d expected t=%0d", m_t, target);
      end
   endtask

   task automatic pulse_load(int sel);
      bus.pat_sel  = 2'(sel);
      bus.pat_load = 1'b1;
      @(negedge clk);
      bus.pat_load = 1'b0;
   endtask

   initial begin
      bus.pat_sel    = '0;
      bus.pat_load   = 1'b0;
      bus.scroll_en  = 1'b0;
      bus.scroll_dir = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;

      check("rst_row", 32'(bus.row_bin), 0);
      check("rst_col", 32'(bus.col), 0);
      check("rst_fs", 32'(bus.frame_start), 0);
      goto(4);
      check("r1_row", 32'(bus.row_bin), 1);
      check("r1_blank", 32'(bus.col), 0);
      goto(5);
      check("r1_col", 32'(bus.col), 32'h0FF0);
      goto(9);
      check("r2_col", 32'(bus.col), 32'h0810);
      goto(63);
      check("r15_fs", 32'(bus.frame_start), 0);
      goto(64);
      check("wrap_row", 32'(bus.row_bin), 0);
      check("wrap_fs", 32'(bus.frame_start), 1);
      goto(65);
      check("fs_once", 32'(bus.frame_start), 0);

      goto(66);
      pulse_load(1);
      goto(70);
      pulse_load(2);
      goto(117);
      check("hold_pat0", 32'(bus.col), 32'h0FF0);
      goto(129);
      check("pat2_r0", 32'(bus.col), 32'hAAAA);
      goto(133);
      check("pat2_r1", 32'(bus.col), 32'h5555);

      goto(136);
      bus.scroll_en  = 1'b1;
      bus.scroll_dir = 1'b0;
      pulse_load(3);
      goto(193);
      check("scroll_l", 32'(bus.col), 32'h0001);
      bus.scroll_dir = 1'b1;
      goto(257);
      check("scroll_r", 32'(bus.col), 32'h8000);
      bus.scroll_en = 1'b0;
      pulse_load(1);
      goto(321);
      check("pat1_r0", 32'(bus.col), 32'hFFFF);

      goto(383);
      pulse_load(3);
      goto(385);
      check("edge_load", 32'(bus.col), 32'h8000);
      goto(389);
      check("edge_r1", 32'(bus.col), 32'h4000);

      goto(400);
      pulse_load(2);
      goto(421);
      check("pre_rst_row", 32'(bus.row_bin), 9);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_row", 32'(bus.row_bin), 0);
      check("mid_rst_col", 32'(bus.col), 0);
      check("mid_rst_fs", 32'(bus.frame_start), 0);
      rst = 1'b0;
      goto(64);
      check("post_rst_fs", 32'(bus.frame_start), 1);
      goto(69);
      check("drop_pend", 32'(bus.col), 32'h0FF0);

      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         rst            = ($urandom_range(0, 799) == 0);
         bus.pat_load   = ($urandom_range(0, 15) == 0);
         bus.pat_sel    = 2'($urandom_range(0, 3));
         bus.scroll_en  = 1'($urandom_range(0, 1));
         bus.scroll_dir = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      rst = 1'b0;
      bus.pat_load = 1'b0;
      repeat (2) @(negedge clk);
      chk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
